// File: rtl/result_writeback.sv
// result_writeback
//   Drains the matmul accumulator result stream, requantizes each result to a
//   signed DATA_WIDTH value (round-half-up arithmetic shift, then saturate) and
//   writes it to consecutive vector SRAM addresses starting at base_addr.
//   The output vector of one matmul pass can then be read as the input vector
//   of the next pass.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               job start pulse, ignored while busy
//   base_addr/count/shift  job parameters, latched on an accepted start
//   in_data/in_valid    signed accumulator result stream
//   in_ready            beat accepted when in_valid && in_ready
//   sram_we/addr/din    registered SRAM write port (one cycle after accept)
//   busy                job in progress
//   done                one-cycle pulse, coincident with the final write
//   sat_seen            sticky: a result of the current job was clamped
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; stream not accepted
// RUN   | accepting results, one write per accepted beat
// DONE  | single cycle; done pulses while the final write is on the port

module result_writeback #(
   parameter int SRAM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH      = 8,
   parameter int ACC_WIDTH       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [SRAM_ADDR_WIDTH-1:0] base_addr,
   input  logic [7:0]                 count,
   input  logic [4:0]                 shift,
   input  logic [ACC_WIDTH-1:0]       in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0]      sram_din,
   output logic                       busy,
   output logic                       done,
   output logic                       sat_seen
);

   localparam int EW = ACC_WIDTH + 1;
   localparam logic signed [EW-1:0] Q_MAX = EW'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] Q_MIN = -Q_MAX - EW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SRAM_ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]                 remaining;
   logic [4:0]                 shift_q;
   logic                       accept;

   logic signed [EW-1:0]  ext;
   logic signed [EW-1:0]  rnd;
   logic signed [EW-1:0]  y;
   logic [DATA_WIDTH-1:0] q_data;
   logic                  q_clamp;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // remaining is a down-counter; the beat that sees it at 1 is the last one
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (count == 8'd0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept && (remaining == 8'd1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_RUN);
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
   end

   // Extra bit of headroom so the rounding add cannot overflow for any shift
   always_comb begin
      ext = {in_data[ACC_WIDTH-1], in_data};
      rnd = ext;
      if (shift_q != 5'd0) begin
         rnd = ext + (EW'(1) << (shift_q - 5'd1));
      end
      y       = rnd >>> shift_q;
      q_clamp = 1'b0;
      q_data  = y[DATA_WIDTH-1:0];
      if (y > Q_MAX) begin
         q_data  = DATA_WIDTH'(Q_MAX);
         q_clamp = 1'b1;
      end else if (y < Q_MIN) begin
         q_data  = DATA_WIDTH'(Q_MIN);
         q_clamp = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr   <= '0;
         remaining <= '0;
         shift_q   <= '0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         sat_seen  <= 1'b0;
      end else begin
         sram_we <= accept;
         if ((state_q == ST_IDLE) && start) begin
            sat_seen  <= 1'b0;
            wr_addr   <= base_addr;
            remaining <= count;
            shift_q   <= shift;
         end
         if (accept) begin
            sram_addr <= wr_addr;
            sram_din  <= q_data;
            wr_addr   <= wr_addr + SRAM_ADDR_WIDTH'(1);
            remaining <= remaining - 8'd1;
            if (q_clamp) begin
               sat_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [7:0]  count;
   logic [4:0]  shift;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [7:0]  sram_din;
   logic        busy;
   logic        done;
   logic        sat_seen;

   int errors = 0;
   int checks = 0;

   // behavioural model of the job as seen from outside
   bit         m_active;
   bit         m_done;
   int         m_left;
   int         m_addr;
   int         m_shift;
   bit         m_sat;
   logic [17:0] wlog[$];

   result_writeback #(
      .SRAM_ADDR_WIDTH(10),
      .DATA_WIDTH(8),
      .ACC_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .count(count),
      .shift(shift),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .sram_we(sram_we),
      .sram_addr(sram_addr),
      .sram_din(sram_din),
      .busy(busy),
      .done(done),
      .sat_seen(sat_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // requantize: round half up by adding half an LSB then flooring division by 2^sh
   function automatic logic [7:0] q_ref(input logic [31:0] x, input int sh, output bit sat);
      longint v;
      v = longint'($signed(x));
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      sat = 1'b0;
      if (v > 127) begin
         v = 127;
         sat = 1'b1;
      end else if (v < -128) begin
         v = -128;
         sat = 1'b1;
      end
      return v[7:0];
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_done   = 0;
      m_left   = 0;
      m_addr   = 0;
      m_shift  = 0;
      m_sat    = 0;
   endtask

   // One clock cycle: drive inputs, check pre-edge handshake, then post-edge outputs
   task automatic cyc(input bit v, input logic [31:0] d, input bit st);
      bit         acc;
      bit         st_acc;
      bit         s;
      bit         exp_we;
      logic [7:0] exp_din;
      logic [9:0] exp_addr;
      in_valid = v;
      in_data  = d;
      start    = st;
      #1;
      chk("in_ready", 32'(in_ready), 32'(m_active));
      chk("busy_pre", 32'(busy), 32'(m_active || m_done));
      acc    = v && m_active;
      st_acc = st && !m_active && !m_done;
      exp_we   = 0;
      exp_din  = 8'h00;
      exp_addr = 10'h000;
      @(posedge clk);
      #1;
      m_done = 0;
      if (acc) begin
         exp_we   = 1;
         exp_addr = 10'(m_addr % 1024);
         exp_din  = q_ref(d, m_shift, s);
         if (s) m_sat = 1;
         m_addr++;
         m_left--;
         if (m_left == 0) begin
            m_active = 0;
            m_done   = 1;
         end
      end
      if (st_acc) begin
         m_sat = 0;
         if (count > 0) begin
            m_active = 1;
            m_left   = int'(count);
            m_addr   = int'(base_addr);
            m_shift  = int'(shift);
         end else begin
            m_done = 1;
         end
      end
      chk("sram_we", 32'(sram_we), 32'(exp_we));
      if (exp_we) begin
         chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
         chk("sram_din", 32'(sram_din), 32'(exp_din));
      end
      chk("done", 32'(done), 32'(m_done));
      chk("sat_seen", 32'(sat_seen), 32'(m_sat));
      chk("busy", 32'(busy), 32'(m_active || m_done));
      if (sram_we === 1'b1) wlog.push_back({sram_addr, sram_din});
      start = 0;
   endtask

   task automatic start_job(input logic [9:0] b, input logic [7:0] c, input logic [4:0] s);
      base_addr = b;
      count     = c;
      shift     = s;
      cyc(0, 32'h0, 1);
   endtask

   task automatic chk_log(input string tag, input int idx, input logic [9:0] a, input logic [7:0] dv);
      logic [17:0] e;
      e = {a, dv};
      if (idx < wlog.size()) chk(tag, 32'(wlog[idx]), 32'(e));
      else chk(tag, 32'h3FFFF, 32'(e));
   endtask

   initial begin
      logic [31:0] d;
      int          guard;
      start     = 0;
      base_addr = 0;
      count     = 0;
      shift     = 0;
      in_data   = 0;
      in_valid  = 0;
      rst       = 0;
      model_reset();
      #2 rst = 1;
      #1;
      chk("rst_we", 32'(sram_we), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_sat", 32'(sat_seen), 0);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_din", 32'(sram_din), 0);
      @(posedge clk);
      #1 rst = 0;

      // basic exact values
      wlog.delete();
      start_job(10'h010, 8'd4, 5'd0);
      cyc(1, 32'd5, 0);
      cyc(1, -32'sd3, 0);
      cyc(1, 32'd127, 0);
      cyc(1, -32'sd128, 0);
      chk("t1_done", 32'(done), 1);
      chk("t1_sat", 32'(sat_seen), 0);
      cyc(0, 32'h0, 0);
      chk("t1_busy_drop", 32'(busy), 0);
      chk("t1_nwrites", wlog.size(), 4);
      chk_log("t1_w0", 0, 10'h010, 8'h05);
      chk_log("t1_w1", 1, 10'h011, 8'hFD);
      chk_log("t1_w2", 2, 10'h012, 8'h7F);
      chk_log("t1_w3", 3, 10'h013, 8'h80);

      // rounding and saturation
      wlog.delete();
      start_job(10'h020, 8'd5, 5'd4);
      cyc(1, 32'd24, 0);
      cyc(1, 32'd23, 0);
      cyc(1, -32'sd24, 0);
      chk("t2_sat_before", 32'(sat_seen), 0);
      cyc(1, 32'd40000, 0);
      chk("t2_sat_rise", 32'(sat_seen), 1);
      cyc(1, -32'sd40000, 0);
      cyc(0, 32'h0, 0);
      chk("t2_sat_hold", 32'(sat_seen), 1);
      chk_log("t2_w0", 0, 10'h020, 8'h02);
      chk_log("t2_w1", 1, 10'h021, 8'h01);
      chk_log("t2_w2", 2, 10'h022, 8'hFF);
      chk_log("t2_w3", 3, 10'h023, 8'h7F);
      chk_log("t2_w4", 4, 10'h024, 8'h80);

      // address wrap
      wlog.delete();
      start_job(10'h3FE, 8'd4, 5'd0);
      for (int i = 0; i < 4; i++) cyc(1, 32'(i), 0);
      cyc(0, 32'h0, 0);
      chk_log("t3_w0", 0, 10'h3FE, 8'h00);
      chk_log("t3_w1", 1, 10'h3FF, 8'h01);
      chk_log("t3_w2", 2, 10'h000, 8'h02);
      chk_log("t3_w3", 3, 10'h001, 8'h03);

      // backpressure gaps, with a start pulse mid-job that must be ignored
      wlog.delete();
      start_job(10'h040, 8'd3, 5'd1);
      cyc(1, 32'd10, 0);
      base_addr = 10'h200;
      count     = 8'd9;
      shift     = 5'd0;
      cyc(0, 32'd99, 1);
      cyc(0, 32'd98, 0);
      cyc(1, 32'd11, 0);
      cyc(0, 32'd97, 0);
      cyc(1, -32'sd7, 0);
      cyc(0, 32'h0, 0);
      chk("t4_nwrites", wlog.size(), 3);
      chk_log("t4_w2", 2, 10'h042, 8'hFD);

      // empty job
      start_job(10'h050, 8'd0, 5'd0);
      chk("t5_done", 32'(done), 1);
      cyc(1, 32'd1, 0);
      cyc(1, 32'd1, 0);

      // reset mid-job
      start_job(10'h060, 8'd8, 5'd0);
      cyc(1, 32'd1, 0);
      cyc(1, 32'd2, 0);
      in_valid = 1;
      rst = 1;
      #1;
      chk("t6_we", 32'(sram_we), 0);
      chk("t6_addr", 32'(sram_addr), 0);
      chk("t6_din", 32'(sram_din), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_ready", 32'(in_ready), 0);
      model_reset();
      cyc(1, 32'd3, 0);
      cyc(1, 32'd4, 0);
      rst = 0;
      wlog.delete();
      start_job(10'h100, 8'd1, 5'd0);
      cyc(1, 32'd7, 0);
      chk("t6_done", 32'(done), 1);
      chk_log("t6_w0", 0, 10'h100, 8'h07);

      // randomized jobs against the model
      for (int j = 0; j < 40; j++) begin
         logic [7:0] c;
         c = (j == 7) ? 8'd255 : ((j % 9 == 3) ? 8'd0 : 8'($urandom_range(1, 12)));
         start_job(10'($urandom), c, 5'($urandom_range(0, 31) % ((j % 2) ? 32 : 12)));
         guard = 0;
         while ((m_active || m_done) && guard < 1000) begin
            if ($urandom_range(0, 1)) d = $urandom;
            else d = 32'($signed($urandom_range(0, 8000)) - 4000);
            base_addr = 10'($urandom);
            count     = 8'($urandom);
            cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 7) == 0);
            guard++;
         end
         chk("rand_job_finished", 32'(m_active || m_done), 0);
         if ($urandom_range(0, 1)) cyc($urandom_range(0, 1), $urandom, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
